// File: rtl/fp_int_convert_unit.sv
// Iterative FP<->integer converter for the F-extension datapath (fcvt.w[u].s / fcvt.s.w[u]).
// One shift per cycle; start/done handshake with busy high while a conversion is in flight.
module fp_int_convert_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  ALUControl,
  input  logic [31:0] src_a,
  output logic [31:0] result,
  output logic        flag_nv,
  output logic        flag_nx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StShift, StRound} state_e;

  state_e      state_q, state_d;
  logic [31:0] m_q, spec_res_q, result_q;
  logic [4:0]  cnt_q, n_q;
  logic        sticky_q, f2i_q, sgn_q, sign_q, spec_q, spec_nv_q, spec_nx_q;
  logic        nv_q, nx_q, done_q;

  // Accept-time decode
  logic [7:0]        f_exp;
  logic [22:0]       f_frac;
  logic signed [9:0] unb;
  logic              is_nan, is_zero;
  logic [31:0]       mag, acc_m, acc_res;
  logic [4:0]        lz, acc_n;
  logic              acc_spec, acc_nv, acc_nx;

  always_comb begin
    f_exp   = src_a[30:23];
    f_frac  = src_a[22:0];
    unb     = $signed({2'b00, f_exp}) - 10'sd127;
    is_nan  = (f_exp == 8'hFF) && (f_frac != 23'd0);
    is_zero = (f_exp == 8'h00) && (f_frac == 23'd0);
    mag     = (ALUControl[0] && src_a[31]) ? -src_a : src_a;
    lz      = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) lz = 5'(31 - i);
    end
    acc_spec = 1'b1;
    acc_res  = 32'd0;
    acc_nv   = 1'b0;
    acc_nx   = 1'b0;
    acc_n    = 5'd0;
    acc_m    = 32'd0;
    if (ALUControl[4:2] == 3'b101) begin
      if (!ALUControl[1]) begin
        acc_m = {1'b1, f_frac, 8'h00};
        if (is_nan) begin
          acc_res = ALUControl[0] ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
          acc_nv  = 1'b1;
        end else if (unb < 10'sd0) begin
          acc_nx = !is_zero;
        end else if (ALUControl[0]) begin
          if (!src_a[31] && unb >= 10'sd31) begin
            acc_res = 32'h7FFF_FFFF;
            acc_nv  = 1'b1;
          end else if (src_a[31] && (unb > 10'sd31 || (unb == 10'sd31 && f_frac != 23'd0))) begin
            acc_res = 32'h8000_0000;
            acc_nv  = 1'b1;
          end else begin
            acc_spec = 1'b0;
            acc_n    = 5'd31 - unb[4:0];
          end
        end else begin
          if (src_a[31]) begin
            acc_nv = 1'b1;
          end else if (unb > 10'sd31) begin
            acc_res = 32'hFFFF_FFFF;
            acc_nv  = 1'b1;
          end else begin
            acc_spec = 1'b0;
            acc_n    = 5'd31 - unb[4:0];
          end
        end
      end else if (src_a != 32'd0) begin
        acc_spec = 1'b0;
        acc_m    = mag;
        acc_n    = lz;
      end
    end
  end

  // Final rounding / sign application
  logic [22:0] mant, mant_r;
  logic        guard, stk, rup, carry;
  logic [7:0]  exp_r;
  logic [31:0] rnd_res;
  logic        rnd_nv, rnd_nx;

  always_comb begin
    mant            = m_q[30:8];
    guard           = m_q[7];
    stk             = |m_q[6:0];
    rup             = guard & (stk | mant[0]);
    {carry, mant_r} = {1'b0, mant} + 24'(rup);
    exp_r           = 8'd158 - {3'b000, n_q} + {7'd0, carry};
    if (spec_q) begin
      rnd_res = spec_res_q;
      rnd_nv  = spec_nv_q;
      rnd_nx  = spec_nx_q;
    end else if (f2i_q) begin
      rnd_res = (sgn_q && sign_q) ? -m_q : m_q;
      rnd_nv  = 1'b0;
      rnd_nx  = sticky_q;
    end else begin
      rnd_res = {sgn_q & sign_q, exp_r, mant_r};
      rnd_nv  = 1'b0;
      rnd_nx  = guard | stk;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (acc_n == 5'd0) ? StRound : StShift;
      StShift: if (cnt_q == 5'd1) state_d = StRound;
      StRound: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy    = (state_q != StIdle);
    done    = done_q;
    result  = result_q;
    flag_nv = nv_q;
    flag_nx = nx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q        <= '0;
      cnt_q      <= '0;
      n_q        <= '0;
      sticky_q   <= 1'b0;
      f2i_q      <= 1'b0;
      sgn_q      <= 1'b0;
      sign_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      spec_nv_q  <= 1'b0;
      spec_nx_q  <= 1'b0;
      result_q   <= '0;
      nv_q       <= 1'b0;
      nx_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state_q == StRound);
      if (state_q == StIdle && start) begin
        m_q        <= acc_m;
        cnt_q      <= acc_n;
        n_q        <= acc_n;
        sticky_q   <= 1'b0;
        f2i_q      <= ~ALUControl[1];
        sgn_q      <= ALUControl[0];
        sign_q     <= src_a[31];
        spec_q     <= acc_spec;
        spec_res_q <= acc_res;
        spec_nv_q  <= acc_nv;
        spec_nx_q  <= acc_nx;
      end else if (state_q == StShift) begin
        cnt_q <= cnt_q - 5'd1;
        if (f2i_q) begin
          m_q      <= m_q >> 1;
          sticky_q <= sticky_q | m_q[0];
        end else begin
          m_q <= m_q << 1;
        end
      end else if (state_q == StRound) begin
        result_q <= rnd_res;
        nv_q     <= rnd_nv;
        nx_q     <= rnd_nx;
      end
    end
  end

endmodule

// File: tb/tb_fp_int_convert_unit.sv
// Scoreboard bench for fp_int_convert_unit: ops push expectations, the done monitor pops and
// checks result, flags and latency.
module tb_fp_int_convert_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  ALUControl;
  logic [31:0] src_a;
  logic [31:0] result;
  logic        flag_nv, flag_nx, busy, done;

  fp_int_convert_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ALUControl(ALUControl),
    .src_a     (src_a),
    .result    (result),
    .flag_nv   (flag_nv),
    .flag_nx   (flag_nx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        nv;
    logic        nx;
    int          lat;
    int          k;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_done = 0;

  localparam logic [4:0] OpWuS = 5'b10100, OpWS = 5'b10101, OpSWu = 5'b10110, OpSW = 5'b10111;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_res"}, result, mon_e.res);
        check({mon_e.tag, "_nv"}, 32'(flag_nv), 32'(mon_e.nv));
        check({mon_e.tag, "_nx"}, 32'(flag_nx), 32'(mon_e.nx));
        check({mon_e.tag, "_lat"}, 32'(cyc - mon_e.k + 1), 32'(mon_e.lat));
        check({mon_e.tag, "_busy_low"}, 32'(busy), 32'd0);
      end
    end
  end

  // Drive start for one cycle at a negedge; the following posedge is edge 1.
  task automatic issue(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] res, input logic nv, input logic nx, input int lat);
    exp_t e;
    e.tag = tag; e.res = res; e.nv = nv; e.nx = nx; e.lat = lat; e.k = cyc + 1;
    sb.push_back(e);
    start      = 1'b1;
    ALUControl = op;
    src_a      = a;
    @(negedge clk);
    start = 1'b0;
    src_a = $urandom;
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (!done && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!done) check({tag, "_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic run(input string tag, input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] res, input logic nv, input logic nx, input int lat);
    issue(tag, op, a, res, nv, nx, lat);
    wait_done(tag);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; ALUControl = '0; src_a = '0;
    repeat (2) @(negedge clk);
    check("rst_result", result, 32'd0);
    check("rst_flags", {30'd0, flag_nv, flag_nx}, 32'd0);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Each run ends in the done cycle, so the next run is a back-to-back start.
    run("pi_w",      OpWS,  32'h4049_0FDB, 32'h0000_0003, 1'b0, 1'b1, 32);
    run("m1_sw",     OpSW,  32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 1'b0, 33);
    run("max_swu",   OpSWu, 32'hFFFF_FFFF, 32'h4F80_0000, 1'b0, 1'b1, 2);
    run("nan_w",     OpWS,  32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2);
    run("p2_31_w",   OpWS,  32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2);
    run("m2_31_w",   OpWS,  32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 2);
    run("m1_wu",     OpWuS, 32'hBF80_0000, 32'h0000_0000, 1'b1, 1'b0, 2);
    run("mhalf_wu",  OpWuS, 32'hBF00_0000, 32'h0000_0000, 1'b0, 1'b1, 2);
    run("p1_5_wu",   OpWuS, 32'h3FC0_0000, 32'h0000_0001, 1'b0, 1'b1, 33);
    run("m2_5_w",    OpWS,  32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 1'b1, 32);
    run("three_sw",  OpSW,  32'h0000_0003, 32'h4040_0000, 1'b0, 1'b0, 32);
    run("tie_swu",   OpSWu, 32'h0100_0001, 32'h4B80_0000, 1'b0, 1'b1, 9);
    run("zero_sw",   OpSW,  32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 2);
    run("inf32_wu",  OpWuS, 32'h4F80_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 2);
    run("top_wu",    OpWuS, 32'h4F7F_FFFF, 32'hFFFF_FF00, 1'b0, 1'b0, 2);
    run("negz_w",    OpWS,  32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 2);
    run("m2_31_sw",  OpSW,  32'h8000_0000, 32'hCF00_0000, 1'b0, 1'b0, 2);
    run("bad_op",    5'b00000, 32'h4049_0FDB, 32'h0000_0000, 1'b0, 1'b0, 2);

    // A start during an in-flight op must be ignored.
    issue("pi_ign", OpWS, 32'h4049_0FDB, 32'h0000_0003, 1'b0, 1'b1, 32);
    repeat (3) @(negedge clk);
    start = 1'b1; ALUControl = OpSW; src_a = 32'h0000_0003;
    @(negedge clk);
    start = 1'b0;
    wait_done("pi_ign");
    @(negedge clk);
    check("idle_after_ign", 32'(busy), 32'd0);

    // Reset mid-operation aborts with no done.
    issue("pi_rst", OpWS, 32'h4049_0FDB, 32'h0000_0003, 1'b0, 1'b1, 32);
    repeat (8) @(negedge clk);
    d0 = n_done;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check("abort_result", result, 32'd0);
    check("abort_flags", {30'd0, flag_nv, flag_nx}, 32'd0);
    check("abort_busy_done", {30'd0, busy, done}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_no_done", 32'(n_done - d0), 32'd0);
    run("m1_sw_post", OpSW, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 1'b0, 33);
    @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
